fetch_sequencer: RTL and testbench

Control-side initiator for PC_COUNTER. It waits for program-memory data at the current PC, latches the instruction, decodes it, and drives hold/jump/branch/ret/preload/in to the counter for exactly one cycle per instruction. It mirrors the counter's 4-entry return stack depth so it can fault on overflow or underflow, and it forwards non-control opcodes to the execute stage as a one-cycle pulse.

---
 rtl/fetch_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// ---------------------------------------------------------------------------
// Control-side initiator for PC_COUNTER. Waits MEM_LAT cycles for the
// instruction at the current PC, latches and decodes it, then drives one
// registered command pulse to the counter per instruction. It keeps a mirror
// of the counter's return-stack depth so that call overflow and return
// underflow stop the machine. Non-control opcodes go to the execute stage as
// a one-cycle exec_valid pulse.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   pc          current PC from the counter (memory is addressed externally)
//   mem_data    instruction word at pc, valid MEM_LAT cycles after pc changes
//   zero_flag   ALU zero flag, sampled while decoding
//   pc_hold, pc_jump, pc_branch, pc_ret, pc_preload, pc_in
//               command pulse and target address for PC_COUNTER
//   exec_valid  one-cycle pulse qualifying exec_op / exec_arg
//   exec_op     opcode forwarded to the execute stage
//   exec_arg    operand forwarded to the execute stage
//   depth       mirrored call depth, 0..STACK_DEPTH
//   halted      sticky, set by HALT or by a stack fault
//   fault       sticky, set by stack overflow or underflow
//
// Every output is a flop. The output flops capture the decode of the state
// that was current at the clock edge, so each command appears in the cycle
// after its state, and depth/halted/fault change in step with it.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int          MEM_LAT     = 2,
   parameter logic [10:0] RESET_VEC   = 11'h000,
   parameter int          STACK_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] pc,
   input  logic [15:0] mem_data,
   input  logic        zero_flag,
   output logic        pc_hold,
   output logic        pc_jump,
   output logic        pc_branch,
   output logic        pc_ret,
   output logic        pc_preload,
   output logic [10:0] pc_in,
   output logic        exec_valid,
   output logic [4:0]  exec_op,
   output logic [10:0] exec_arg,
   output logic [2:0]  depth,
   output logic        halted,
   output logic        fault
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_LAT - 1);
   localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_JMP  = 5'b00001;
   localparam logic [4:0] OP_CALL = 5'b00010;
   localparam logic [4:0] OP_RET  = 5'b00011;
   localparam logic [4:0] OP_BZ   = 5'b00100;
   localparam logic [4:0] OP_HALT = 5'b11111;

   typedef enum logic [2:0] {
      BOOT,
      FETCH,
      DECODE,
      ISSUE,
      HALT
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic [15:0]      instr_q;
   logic             bz_taken;
   logic [2:0]       depth_q;
   logic             halted_q;
   logic             fault_q;

   logic [4:0]       opcode;
   logic [10:0]      operand;
   logic             call_overflow;
   logic             ret_underflow;

   logic             hold_d;
   logic             jump_d;
   logic             branch_d;
   logic             ret_d;
   logic             preload_d;
   logic [10:0]      in_d;
   logic             exec_valid_d;
   logic [4:0]       exec_op_d;
   logic [10:0]      exec_arg_d;

   // pc is informational only; memory is addressed outside this block.
   logic             pc_unused;
   assign pc_unused = ^pc;

   assign opcode        = instr_q[15:11];
   assign operand       = instr_q[10:0];
   assign call_overflow = (opcode == OP_CALL) && (depth_q == DEPTH_MAX);
   assign ret_underflow = (opcode == OP_RET) && (depth_q == 3'd0);

   // State register. Reset always restarts from BOOT so the counter is
   // re-preloaded with the reset vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BOOT;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. FETCH leaves once the latency counter has run out;
   // DECODE diverts to HALT on a stack fault or a HALT opcode.
   always_comb begin
      next_state = state;
      case (state)
         BOOT:   next_state = FETCH;
         FETCH:  if (wait_cnt == '0) next_state = DECODE;
         DECODE: begin
            if (call_overflow || ret_underflow || (opcode == OP_HALT)) begin
               next_state = HALT;
            end else begin
               next_state = ISSUE;
            end
         end
         ISSUE:  next_state = FETCH;
         HALT:   next_state = HALT;
         default: next_state = BOOT;
      endcase
   end

   // Output decode. Only BOOT and ISSUE command the counter; every other
   // state leaves all lines low. Unused address/operand fields are held at
   // zero so idle cycles are clean.
   always_comb begin
      hold_d       = 1'b0;
      jump_d       = 1'b0;
      branch_d     = 1'b0;
      ret_d        = 1'b0;
      preload_d    = 1'b0;
      in_d         = '0;
      exec_valid_d = 1'b0;
      exec_op_d    = '0;
      exec_arg_d   = '0;
      case (state)
         BOOT: begin
            hold_d    = 1'b1;
            jump_d    = 1'b1;
            preload_d = 1'b1;
            in_d      = RESET_VEC;
         end
         ISSUE: begin
            hold_d = 1'b1;
            case (opcode)
               OP_NOP: ;
               OP_HALT: ;
               OP_JMP: begin
                  jump_d    = 1'b1;
                  preload_d = 1'b1;
                  in_d      = operand;
               end
               OP_CALL: begin
                  jump_d   = 1'b1;
                  branch_d = 1'b1;
                  in_d     = {1'b0, operand[9:0]};
               end
               OP_RET: begin
                  jump_d = 1'b1;
                  ret_d  = 1'b1;
               end
               OP_BZ: begin
                  if (bz_taken) begin
                     jump_d    = 1'b1;
                     preload_d = 1'b1;
                     in_d      = operand;
                  end
               end
               default: begin
                  exec_valid_d = 1'b1;
                  exec_op_d    = opcode;
                  exec_arg_d   = operand;
               end
            endcase
         end
         default: ;
      endcase
   end

   // Output flops. Reset forces every line low, so a reset in the middle
   // of an instruction never lets a partial command through.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_hold    <= 1'b0;
         pc_jump    <= 1'b0;
         pc_branch  <= 1'b0;
         pc_ret     <= 1'b0;
         pc_preload <= 1'b0;
         pc_in      <= '0;
         exec_valid <= 1'b0;
         exec_op    <= '0;
         exec_arg   <= '0;
      end else begin
         pc_hold    <= hold_d;
         pc_jump    <= jump_d;
         pc_branch  <= branch_d;
         pc_ret     <= ret_d;
         pc_preload <= preload_d;
         pc_in      <= in_d;
         exec_valid <= exec_valid_d;
         exec_op    <= exec_op_d;
         exec_arg   <= exec_arg_d;
      end
   end

   // Datapath: the latency counter reloads whenever we are outside FETCH, so
   // it holds MEM_LAT-1 on entry and FETCH lasts exactly MEM_LAT cycles.
   // The zero flag and the fault checks are taken in DECODE; the depth
   // mirror moves at the same edge the CALL/RET command is registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= WAIT_LOAD;
         instr_q  <= '0;
         bz_taken <= 1'b0;
         depth_q  <= '0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         if (state == FETCH) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end else begin
            wait_cnt <= WAIT_LOAD;
         end
         if ((state == FETCH) && (wait_cnt == '0)) begin
            instr_q <= mem_data;
         end
         if (state == DECODE) begin
            bz_taken <= zero_flag;
            if (call_overflow || ret_underflow) begin
               fault_q  <= 1'b1;
               halted_q <= 1'b1;
            end else if (opcode == OP_HALT) begin
               halted_q <= 1'b1;
            end
         end
         if (state == ISSUE) begin
            if (opcode == OP_CALL) begin
               depth_q <= depth_q + 3'd1;
            end else if (opcode == OP_RET) begin
               depth_q <= depth_q - 3'd1;
            end
         end
      end
   end

   assign depth  = depth_q;
   assign halted = halted_q;
   assign fault  = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// ---------------------------------------------------------------------------
// Scoreboard bench for fetch_sequencer. Programs (directed and random) are
// fed one word at a time on mem_data; for each word a reference model of the
// instruction set predicts the counter command it must produce and pushes
// it into a queue. A monitor process pops and compares whenever the DUT
// shows a command or an execute pulse, and also checks command spacing and
// that the command lines are low in idle cycles.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam int          MEM_LAT     = 2;
   localparam logic [10:0] RESET_VEC   = 11'h010;
   localparam int          STACK_DEPTH = 4;
   localparam int          SPACING     = MEM_LAT + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] pc = '0;
   logic [15:0] mem_data = '0;
   logic        zero_flag = 1'b0;
   logic        pc_hold;
   logic        pc_jump;
   logic        pc_branch;
   logic        pc_ret;
   logic        pc_preload;
   logic [10:0] pc_in;
   logic        exec_valid;
   logic [4:0]  exec_op;
   logic [10:0] exec_arg;
   logic [2:0]  depth;
   logic        halted;
   logic        fault;

   // pulses = {hold, jump, branch, ret, preload}
   typedef struct packed {
      logic [4:0]  pulses;
      logic [10:0] pin;
      logic        ev;
      logic [4:0]  op;
      logic [10:0] arg;
      logic [2:0]  dep;
   } exp_t;

   exp_t        expQ[$];
   logic [15:0] progQ[$];
   logic        zQ[$];

   int checks      = 0;
   int failures    = 0;
   int eventCount  = 0;
   int cycleCount  = 0;
   int lastEvCycle = -1;
   int modelDepth  = 0;
   bit modelHalted = 1'b0;
   bit modelFault  = 1'b0;

   fetch_sequencer #(
      .MEM_LAT(MEM_LAT),
      .RESET_VEC(RESET_VEC),
      .STACK_DEPTH(STACK_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pc(pc),
      .mem_data(mem_data),
      .zero_flag(zero_flag),
      .pc_hold(pc_hold),
      .pc_jump(pc_jump),
      .pc_branch(pc_branch),
      .pc_ret(pc_ret),
      .pc_preload(pc_preload),
      .pc_in(pc_in),
      .exec_valid(exec_valid),
      .exec_op(exec_op),
      .exec_arg(exec_arg),
      .depth(depth),
      .halted(halted),
      .fault(fault)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Monitor: runs forever on the falling edge, away from the DUT's edge.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            cycleCount++;
            if (!pc_hold) begin
               checkOutput("idle_lines", {28'd0, pc_jump, pc_branch, pc_ret, pc_preload}, 32'd0);
            end
            if (pc_hold || exec_valid) begin
               if (expQ.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_pulse actual=hold%0b/exec%0b required=no_pulse", pc_hold, exec_valid);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("pc_pulses", {27'd0, pc_hold, pc_jump, pc_branch, pc_ret, pc_preload}, {27'd0, e.pulses});
                  checkOutput("pc_in", {21'd0, pc_in}, {21'd0, e.pin});
                  checkOutput("exec", {15'd0, exec_valid, exec_op, exec_arg}, {15'd0, e.ev, e.op, e.arg});
                  checkOutput("depth", {29'd0, depth}, {29'd0, e.dep});
                  checkOutput("flags_running", {30'd0, halted, fault}, 32'd0);
               end
               if (lastEvCycle >= 0) begin
                  checkOutput("spacing", 32'(cycleCount - lastEvCycle), 32'(SPACING));
               end
               lastEvCycle = cycleCount;
               eventCount++;
            end
         end
      end
   endtask

   // Reference model: from the instruction rules, predict the command for
   // one word, update the model call depth, and tell the caller whether the
   // machine stops on this word.
   task automatic applyStimulus(input logic [15:0] word, input logic z, output bit stops);
      exp_t        e;
      logic [4:0]  op;
      logic [10:0] arg;
      op        = word[15:11];
      arg       = word[10:0];
      mem_data  = word;
      zero_flag = z;
      pc        = pc + 11'd1;
      stops     = 1'b0;
      e         = '0;
      e.pulses  = 5'b10000;
      case (op)
         5'd0: ;
         5'd1: begin
            e.pulses = 5'b11001;
            e.pin    = arg;
         end
         5'd2: begin
            if (modelDepth == STACK_DEPTH) begin
               modelFault  = 1'b1;
               modelHalted = 1'b1;
               stops       = 1'b1;
            end else begin
               e.pulses = 5'b11100;
               e.pin    = {1'b0, arg[9:0]};
               modelDepth++;
            end
         end
         5'd3: begin
            if (modelDepth == 0) begin
               modelFault  = 1'b1;
               modelHalted = 1'b1;
               stops       = 1'b1;
            end else begin
               e.pulses = 5'b11010;
               modelDepth--;
            end
         end
         5'd4: begin
            if (z) begin
               e.pulses = 5'b11001;
               e.pin    = arg;
            end
         end
         5'd31: begin
            modelHalted = 1'b1;
            stops       = 1'b1;
         end
         default: begin
            e.ev  = 1'b1;
            e.op  = op;
            e.arg = arg;
         end
      endcase
      e.dep = 3'(modelDepth);
      if (!stops) expQ.push_back(e);
   endtask

   // Assert reset during whatever the DUT is doing, check the cleared
   // outputs one cycle later, then arm the scoreboard with the BOOT command.
   task automatic applyReset();
      exp_t b;
      @(negedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_pc", {16'd0, pc_hold, pc_jump, pc_branch, pc_ret, pc_preload, pc_in}, 32'd0);
      checkOutput("reset_exec", {15'd0, exec_valid, exec_op, exec_arg}, 32'd0);
      checkOutput("reset_status", {27'd0, depth, halted, fault}, 32'd0);
      @(negedge clk);
      #1;
      expQ.delete();
      eventCount  = 0;
      lastEvCycle = -1;
      modelDepth  = 0;
      modelHalted = 1'b0;
      modelFault  = 1'b0;
      b           = '0;
      b.pulses    = 5'b11001;
      b.pin       = RESET_VEC;
      expQ.push_back(b);
   endtask

   // Bounded wait for the monitor to have seen 'target' commands.
   task automatic waitEvents(input int target, output bit ok);
      int budget;
      budget = 3 * SPACING;
      while ((eventCount < target) && (budget > 0)) begin
         @(negedge clk);
         #1;
         budget--;
      end
      ok = (eventCount >= target);
      checkOutput("event_count", 32'(eventCount), 32'(target));
   endtask

   // Run the program in progQ/zQ from reset. Word k is presented after the
   // k-th command has been observed; a stopping word is followed by a quiet
   // window in which nothing may be issued.
   task automatic runProgram();
      bit stops;
      bit ok;
      applyReset();
      stops = 1'b0;
      ok    = 1'b1;
      for (int k = 0; (k < progQ.size()) && !stops && ok; k++) begin
         applyStimulus(progQ[k], zQ[k], stops);
         if (k == 0) begin
            rst = 1'b0;
            @(negedge clk);
            #1;
            checkOutput("boot_first_cycle", 32'(eventCount), 32'd1);
         end
         if (!stops) begin
            waitEvents(k + 2, ok);
         end else begin
            repeat (24) @(negedge clk);
            #1;
            checkOutput("quiet_after_stop", 32'(eventCount), 32'(k + 1));
            checkOutput("halted", 32'(halted), 32'(modelHalted));
            checkOutput("fault", 32'(fault), 32'(modelFault));
            checkOutput("depth_frozen", {29'd0, depth}, 32'(modelDepth));
            checkOutput("pc_in_idle", {21'd0, pc_in}, 32'd0);
         end
      end
   endtask

   task automatic addInstr(input logic [15:0] w, input logic z);
      progQ.push_back(w);
      zQ.push_back(z);
   endtask

   task automatic newProgram();
      progQ.delete();
      zQ.delete();
   endtask

   // Weighted random instruction: control opcodes are favoured so that the
   // stack limits are reached regularly.
   function automatic logic [15:0] randomWord();
      int          r;
      logic [4:0]  op;
      logic [10:0] arg;
      r   = int'($urandom_range(0, 15));
      arg = 11'($urandom);
      if (r < 2)       op = 5'd0;
      else if (r < 4)  op = 5'd1;
      else if (r < 7)  op = 5'd2;
      else if (r < 9)  op = 5'd3;
      else if (r < 11) op = 5'd4;
      else if (r < 15) op = 5'($urandom_range(5, 30));
      else             op = 5'd31;
      return {op, arg};
   endfunction

   // Directed programs first, then random ones, then a final reset check.
   initial begin
      int n;
      fork
         monitor();
      join_none

      newProgram();
      addInstr(16'h0000, 1'b0);
      addInstr(16'h0000, 1'b1);
      addInstr(16'h0000, 1'b0);
      runProgram();

      newProgram();
      addInstr(16'h1205, 1'b0);
      addInstr(16'h1800, 1'b0);
      runProgram();

      newProgram();
      for (int i = 0; i < 5; i++) addInstr(16'h1003, 1'b0);
      runProgram();

      newProgram();
      addInstr(16'h2033, 1'b1);
      addInstr(16'h2033, 1'b0);
      addInstr(16'h0FFF, 1'b0);
      runProgram();

      newProgram();
      addInstr(16'h507F, 1'b0);
      runProgram();

      newProgram();
      addInstr(16'h0000, 1'b0);
      addInstr(16'hF800, 1'b0);
      runProgram();

      newProgram();
      addInstr(16'h1800, 1'b0);
      runProgram();

      for (int p = 0; p < 10; p++) begin
         newProgram();
         n = int'($urandom_range(6, 14));
         for (int i = 0; i < n; i++) addInstr(randomWord(), 1'($urandom_range(0, 1)));
         runProgram();
      end

      applyReset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
